pong_game_ctrl: RTL and testbench



---
 rtl/pong_pkg.sv | 26 ++
 rtl/frame_timer.sv | 28 ++
 rtl/pong_game_ctrl.sv | 176 +++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and default constants for the Pong match controller.
// Imported by the RTL and the bench so both agree on timing and scoring.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SERVE,
    PLAY,
    PAUSE,
    POINT,
    END
  } state_t;

  localparam int WIN_SCORE_D    = 5;
  localparam int SCOREW_D       = 4;
  localparam int SERVE_FRAMES_D = 60;
  localparam int POINT_FRAMES_D = 30;
  localparam int END_FRAMES_D   = 300;
  localparam int FRAMEW_D       = 9;

  function automatic logic is_timed(input state_t s);
    return (s == SERVE) || (s == POINT) || (s == END);
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Loadable frame down-counter; advances once per animate pulse.
// Reports done on the animate that finds it already at zero.
module frame_timer #(
  parameter int FRAMEW = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [FRAMEW-1:0] i_load_val,
  input  logic              i_adv,
  output logic              o_done
);

  logic [FRAMEW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_adv && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = i_adv && (r_cnt == '0);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: attract/serve/play/pause/point/end states,
// score keeping and frame-timed delays, all outputs registered.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = WIN_SCORE_D,
  parameter int SCOREW       = SCOREW_D,
  parameter int SERVE_FRAMES = SERVE_FRAMES_D,
  parameter int POINT_FRAMES = POINT_FRAMES_D,
  parameter int END_FRAMES   = END_FRAMES_D,
  parameter int FRAMEW       = FRAMEW_D
) (
  input  logic              clk_pix,
  input  logic              rst_n,
  input  logic              animate,
  input  logic              sig_ctrl,
  input  logic              miss_l,
  input  logic              miss_r,
  output state_t            state,
  output logic              ball_move,
  output logic              ball_reset,
  output logic              serve_dx,
  output logic              p1_human,
  output logic [SCOREW-1:0] score_l,
  output logic [SCOREW-1:0] score_r,
  output logic              winner
);

  localparam logic [SCOREW-1:0] L_WIN = SCOREW'(WIN_SCORE);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SCOREW-1:0] r_score_l;
  logic [SCOREW-1:0] r_score_r;
  logic [SCOREW-1:0] w_score_l_nxt;
  logic [SCOREW-1:0] w_score_r_nxt;
  logic              r_dx;
  logic              w_dx_nxt;
  logic              r_winner;
  logic              w_winner_nxt;
  logic              r_ball_reset;
  logic              w_ball_reset_nxt;
  logic              r_ball_move;
  logic              r_p1_human;
  logic              w_done;
  logic              w_load;
  logic              w_adv;
  logic [FRAMEW-1:0] w_load_val;

  function automatic logic [SCOREW-1:0] sat_inc(
    input logic [SCOREW-1:0] s
  );
    return (s >= L_WIN) ? s : s + 1'b1;
  endfunction

  // The timer only runs in timed states, so PAUSE holds it.
  assign w_adv  = is_timed(r_state) && animate;
  assign w_load = (w_state_nxt != r_state) &&
                  is_timed(w_state_nxt);

  always_comb begin
    w_load_val = FRAMEW'(END_FRAMES - 1);
    unique case (1'b1)
      (w_state_nxt == SERVE):
        w_load_val = FRAMEW'(SERVE_FRAMES - 1);
      (w_state_nxt == POINT):
        w_load_val = FRAMEW'(POINT_FRAMES - 1);
      default: ;
    endcase
  end

  frame_timer #(
    .FRAMEW(FRAMEW)
  ) u_timer (
    .clk       (clk_pix),
    .rst_n     (rst_n),
    .i_load    (w_load),
    .i_load_val(w_load_val),
    .i_adv     (w_adv),
    .o_done    (w_done)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_score_l_nxt    = r_score_l;
    w_score_r_nxt    = r_score_r;
    w_dx_nxt         = r_dx;
    w_winner_nxt     = r_winner;
    w_ball_reset_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (sig_ctrl) begin
          w_state_nxt      = INIT;
          w_score_l_nxt    = '0;
          w_score_r_nxt    = '0;
          w_dx_nxt         = 1'b0;
          w_winner_nxt     = 1'b0;
          w_ball_reset_nxt = 1'b1;
        end
      end
      INIT: w_state_nxt = SERVE;
      SERVE: begin
        if (w_done) w_state_nxt = PLAY;
      end
      PLAY: begin
        if (sig_ctrl) begin
          w_state_nxt = PAUSE;
        end else if (animate && (miss_l || miss_r)) begin
          w_state_nxt = POINT;
          if (miss_l && !miss_r) begin
            w_score_r_nxt = sat_inc(r_score_r);
            w_dx_nxt      = 1'b1;
          end else if (miss_r && !miss_l) begin
            w_score_l_nxt = sat_inc(r_score_l);
            w_dx_nxt      = 1'b0;
          end
        end
      end
      PAUSE: begin
        if (sig_ctrl) w_state_nxt = PLAY;
      end
      POINT: begin
        if (w_done) begin
          if ((r_score_l == L_WIN) || (r_score_r == L_WIN)) begin
            w_state_nxt  = END;
            w_winner_nxt = (r_score_r == L_WIN);
          end else begin
            w_state_nxt      = SERVE;
            w_ball_reset_nxt = 1'b1;
          end
        end
      end
      END: begin
        if (sig_ctrl || w_done) begin
          w_state_nxt      = IDLE;
          w_ball_reset_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_score_l    <= '0;
      r_score_r    <= '0;
      r_dx         <= 1'b0;
      r_winner     <= 1'b0;
      r_ball_reset <= 1'b0;
      r_ball_move  <= 1'b1;
      r_p1_human   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_score_l    <= w_score_l_nxt;
      r_score_r    <= w_score_r_nxt;
      r_dx         <= w_dx_nxt;
      r_winner     <= w_winner_nxt;
      r_ball_reset <= w_ball_reset_nxt;
      r_ball_move  <= (w_state_nxt == IDLE) ||
                      (w_state_nxt == PLAY);
      r_p1_human   <= (w_state_nxt != IDLE) &&
                      (w_state_nxt != END);
    end
  end

  assign state      = r_state;
  assign ball_move  = r_ball_move;
  assign ball_reset = r_ball_reset;
  assign serve_dx   = r_dx;
  assign p1_human   = r_p1_human;
  assign score_l    = r_score_l;
  assign score_r    = r_score_r;
  assign winner     = r_winner;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed self-checking bench for pong_game_ctrl.
// Walks full matches, pause handling and asynchronous reset.
module tb_pong_game_ctrl;
  import pong_pkg::*;

  logic       clk_pix  = 1'b0;
  logic       rst_n    = 1'b0;
  logic       animate  = 1'b0;
  logic       sig_ctrl = 1'b0;
  logic       miss_l   = 1'b0;
  logic       miss_r   = 1'b0;
  state_t     state;
  logic       ball_move;
  logic       ball_reset;
  logic       serve_dx;
  logic       p1_human;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       winner;

  int vectors     = 0;
  int miscompares = 0;

  pong_game_ctrl dut (
    .clk_pix   (clk_pix),
    .rst_n     (rst_n),
    .animate   (animate),
    .sig_ctrl  (sig_ctrl),
    .miss_l    (miss_l),
    .miss_r    (miss_r),
    .state     (state),
    .ball_move (ball_move),
    .ball_reset(ball_reset),
    .serve_dx  (serve_dx),
    .p1_human  (p1_human),
    .score_l   (score_l),
    .score_r   (score_r),
    .winner    (winner)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input state_t exp);
    chk(tag, 32'(state), 32'(exp));
  endtask

  task automatic pulse_ctrl();
    sig_ctrl = 1'b1;
    tick();
    sig_ctrl = 1'b0;
  endtask

  task automatic anim(input logic l, input logic r);
    animate = 1'b1;
    miss_l  = l;
    miss_r  = r;
    tick();
    animate = 1'b0;
    miss_l  = 1'b0;
    miss_r  = 1'b0;
  endtask

  task automatic anims(input int n);
    repeat (n) begin
      anim(1'b0, 1'b0);
      tick();
    end
  endtask

  task automatic serve_to_play();
    anims(59);
    chk_st("serve_hold", SERVE);
    chk("serve_move", 32'(ball_move), 32'd0);
    anim(1'b0, 1'b0);
    chk_st("serve_exp", PLAY);
    chk("play_move", 32'(ball_move), 32'd1);
  endtask

  task automatic point_to_serve();
    anims(29);
    chk_st("point_hold", POINT);
    anim(1'b0, 1'b0);
    chk_st("point_exp", SERVE);
    chk("point_brst", 32'(ball_reset), 32'd1);
    tick();
    chk("brst_pulse", 32'(ball_reset), 32'd0);
  endtask

  initial begin
    repeat (3) tick();
    chk_st("rst_state", IDLE);
    chk("rst_move", 32'(ball_move), 32'd1);
    chk("rst_brst", 32'(ball_reset), 32'd0);
    chk("rst_p1h", 32'(p1_human), 32'd0);
    chk("rst_scl", 32'(score_l), 32'd0);
    chk("rst_scr", 32'(score_r), 32'd0);
    chk("rst_win", 32'(winner), 32'd0);
    chk("rst_dx", 32'(serve_dx), 32'd0);
    rst_n = 1'b1;

    pulse_ctrl();
    chk_st("init", INIT);
    chk("init_brst", 32'(ball_reset), 32'd1);
    chk("init_move", 32'(ball_move), 32'd0);
    tick();
    chk_st("serve", SERVE);
    chk("serve_brst", 32'(ball_reset), 32'd0);
    chk("serve_p1h", 32'(p1_human), 32'd1);
    chk("serve_scl", 32'(score_l), 32'd0);
    pulse_ctrl();
    chk_st("serve_ign_ctl", SERVE);
    serve_to_play();

    anim(1'b0, 1'b1);
    chk_st("missr_st", POINT);
    chk("missr_scl", 32'(score_l), 32'd1);
    chk("missr_dx", 32'(serve_dx), 32'd0);
    chk("point_move", 32'(ball_move), 32'd0);
    point_to_serve();
    serve_to_play();

    anim(1'b1, 1'b0);
    chk_st("missl_st", POINT);
    chk("missl_scr", 32'(score_r), 32'd1);
    chk("missl_dx", 32'(serve_dx), 32'd1);
    point_to_serve();
    serve_to_play();

    anim(1'b1, 1'b1);
    chk_st("both_st", POINT);
    chk("both_scl", 32'(score_l), 32'd1);
    chk("both_scr", 32'(score_r), 32'd1);
    chk("both_dx", 32'(serve_dx), 32'd1);
    point_to_serve();
    serve_to_play();

    sig_ctrl = 1'b1;
    animate  = 1'b1;
    miss_l   = 1'b1;
    tick();
    sig_ctrl = 1'b0;
    animate  = 1'b0;
    miss_l   = 1'b0;
    chk_st("pause_st", PAUSE);
    chk("pause_scr", 32'(score_r), 32'd1);
    chk("pause_move", 32'(ball_move), 32'd0);
    anim(1'b1, 1'b0);
    anim(1'b0, 1'b1);
    chk_st("pause_hold", PAUSE);
    chk("pause_ign_l", 32'(score_l), 32'd1);
    chk("pause_ign_r", 32'(score_r), 32'd1);
    pulse_ctrl();
    chk_st("resume", PLAY);
    chk("resume_move", 32'(ball_move), 32'd1);

    for (int i = 2; i <= 5; i++) begin
      anim(1'b0, 1'b1);
      chk_st("lwin_pt", POINT);
      chk("lwin_scl", 32'(score_l), 32'(i));
      if (i < 5) begin
        point_to_serve();
        serve_to_play();
      end
    end
    anims(29);
    chk_st("lwin_hold", POINT);
    anim(1'b0, 1'b0);
    chk_st("lwin_end", END);
    chk("lwin_win", 32'(winner), 32'd0);
    chk("lwin_scl5", 32'(score_l), 32'd5);
    chk("lwin_p1h", 32'(p1_human), 32'd0);
    chk("lwin_brst", 32'(ball_reset), 32'd0);
    anims(299);
    chk_st("end_hold", END);
    anim(1'b0, 1'b0);
    chk_st("end_exp", IDLE);
    chk("end_brst", 32'(ball_reset), 32'd1);
    chk("idle_move", 32'(ball_move), 32'd1);
    tick();
    chk("idle_brst0", 32'(ball_reset), 32'd0);
    anim(1'b1, 1'b1);
    chk_st("idle_miss", IDLE);

    pulse_ctrl();
    chk_st("init2", INIT);
    chk("init2_scl", 32'(score_l), 32'd0);
    chk("init2_scr", 32'(score_r), 32'd0);
    tick();
    for (int i = 1; i <= 5; i++) begin
      serve_to_play();
      anim(1'b1, 1'b0);
      chk("rwin_scr", 32'(score_r), 32'(i));
      if (i < 5) point_to_serve();
    end
    anims(30);
    chk_st("rwin_end", END);
    chk("rwin_win", 32'(winner), 32'd1);
    anims(5);
    pulse_ctrl();
    chk_st("end_ctl", IDLE);
    chk("end_ctl_brst", 32'(ball_reset), 32'd1);

    tick();
    pulse_ctrl();
    tick();
    for (int i = 1; i <= 3; i++) begin
      serve_to_play();
      anim(1'b1, 1'b0);
      if (i < 3) point_to_serve();
    end
    chk_st("mid_point", POINT);
    chk("mid_scr", 32'(score_r), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_st("arst_state", IDLE);
    chk("arst_scr", 32'(score_r), 32'd0);
    chk("arst_dx", 32'(serve_dx), 32'd0);
    chk("arst_move", 32'(ball_move), 32'd1);
    chk("arst_p1h", 32'(p1_human), 32'd0);
    tick();
    tick();
    chk("arst_brst", 32'(ball_reset), 32'd0);
    rst_n = 1'b1;
    pulse_ctrl();
    chk_st("post_rst_ctl", INIT);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
